enum_coef_reload_ctrl: RTL and testbench

- Sequences run-time reload of FIR coefficients into a pair of coefficient shift registers (banks A/B) used as active/shadow banks.
- Accepts a valid/ready coefficient stream and counts exactly TAPS words into the shadow bank.
- Swaps banks only when the datapath flags a safe point, so the filter never computes with a partially loaded set.

---
 rtl/enum_coef_reload_ctrl.sv | 126 ++++++++++++
 tb/tb_enum_coef_reload_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/enum_coef_reload_ctrl.sv
// Coefficient reload sequencer: streams TAPS words into the shadow bank of an
// active/shadow coefficient pair and swaps banks only at a datapath safe point.
module enum_coef_reload_ctrl #(
    parameter int TAPS       = 100,
    parameter int COEF_WIDTH = 12,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  nGrst,
    input  logic                  clkEn,
    input  logic                  rstn,
    input  logic                  load_start,
    input  logic [COEF_WIDTH-1:0] coef_in,
    input  logic                  coef_in_valid,
    output logic                  coef_in_ready,
    input  logic                  swap_ok,
    output logic [COEF_WIDTH-1:0] coefo,
    output logic [1:0]            coefo_valid,
    output logic                  bank_sel,
    output logic [CNT_WIDTH-1:0]  load_cnt,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_abort
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_SWAP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TAPS - 1);

    state_t                  state, state_nxt;
    logic [COEF_WIDTH-1:0]   coefo_nxt;
    logic [1:0]              coefo_valid_nxt;
    logic                    bank_sel_nxt;
    logic [CNT_WIDTH-1:0]    load_cnt_nxt;
    logic                    load_done_nxt;
    logic                    load_abort_nxt;
    logic                    accept;

    assign coef_in_ready = clkEn && (state == S_LOAD);
    assign accept        = coef_in_valid && coef_in_ready;
    assign busy          = (state != S_IDLE);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt       = state;
        coefo_nxt       = coefo;
        coefo_valid_nxt = 2'b00;
        bank_sel_nxt    = bank_sel;
        load_cnt_nxt    = load_cnt;
        load_done_nxt   = 1'b0;
        load_abort_nxt  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_nxt    = S_LOAD;
                    load_cnt_nxt = '0;
                end
            end
            S_LOAD: begin
                // A restart discards any word offered in the same cycle.
                if (load_start) begin
                    load_cnt_nxt   = '0;
                    load_abort_nxt = 1'b1;
                end else if (accept) begin
                    coefo_nxt       = coef_in;
                    coefo_valid_nxt = bank_sel ? 2'b01 : 2'b10;
                    load_cnt_nxt    = load_cnt + 1'b1;
                    if (load_cnt == LAST_CNT)
                        state_nxt = S_WAIT_SWAP;
                end
            end
            S_WAIT_SWAP: begin
                if (load_start) begin
                    state_nxt      = S_LOAD;
                    load_cnt_nxt   = '0;
                    load_abort_nxt = 1'b1;
                end else if (swap_ok) begin
                    state_nxt     = S_IDLE;
                    bank_sel_nxt  = ~bank_sel;
                    load_cnt_nxt  = '0;
                    load_done_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            state       <= S_IDLE;
            coefo       <= '0;
            coefo_valid <= 2'b00;
            bank_sel    <= 1'b0;
            load_cnt    <= '0;
            load_done   <= 1'b0;
            load_abort  <= 1'b0;
        end else if (clkEn) begin
            if (!rstn) begin
                state       <= S_IDLE;
                coefo       <= '0;
                coefo_valid <= 2'b00;
                bank_sel    <= 1'b0;
                load_cnt    <= '0;
                load_done   <= 1'b0;
                load_abort  <= 1'b0;
            end else begin
                state       <= state_nxt;
                coefo       <= coefo_nxt;
                coefo_valid <= coefo_valid_nxt;
                bank_sel    <= bank_sel_nxt;
                load_cnt    <= load_cnt_nxt;
                load_done   <= load_done_nxt;
                load_abort  <= load_abort_nxt;
            end
        end
    end

endmodule

// File: tb/tb_enum_coef_reload_ctrl.sv
// Directed bench for enum_coef_reload_ctrl with TAPS=4: bank fill/swap,
// stalls, restarts, clock-enable freeze and both reset paths.
module tb_enum_coef_reload_ctrl;

    localparam int TAPS = 4;
    localparam int CW   = 12;
    localparam int NW   = 3;

    logic          clk = 1'b0;
    logic          nGrst, clkEn, rstn, load_start, coef_in_valid, swap_ok;
    logic [CW-1:0] coef_in;
    logic          coef_in_ready, bank_sel, busy, load_done, load_abort;
    logic [CW-1:0] coefo;
    logic [1:0]    coefo_valid;
    logic [NW-1:0] load_cnt;

    int checks   = 0;
    int failures = 0;

    enum_coef_reload_ctrl #(.TAPS(TAPS), .COEF_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk(clk), .nGrst(nGrst), .clkEn(clkEn), .rstn(rstn),
        .load_start(load_start), .coef_in(coef_in), .coef_in_valid(coef_in_valid),
        .coef_in_ready(coef_in_ready), .swap_ok(swap_ok), .coefo(coefo),
        .coefo_valid(coefo_valid), .bank_sel(bank_sel), .load_cnt(load_cnt),
        .busy(busy), .load_done(load_done), .load_abort(load_abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [1:0] ev, input logic eb,
                                input logic [NW-1:0] ec, input logic ebusy,
                                input logic edone, input logic eabort);
        check({tag, ".coefo_valid"}, 32'(coefo_valid), 32'(ev));
        check({tag, ".bank_sel"},    32'(bank_sel),    32'(eb));
        check({tag, ".load_cnt"},    32'(load_cnt),    32'(ec));
        check({tag, ".busy"},        32'(busy),        32'(ebusy));
        check({tag, ".load_done"},   32'(load_done),   32'(edone));
        check({tag, ".load_abort"},  32'(load_abort),  32'(eabort));
    endtask

    // Offer one word for one cycle and check it lands in the expected bank.
    task automatic send(input logic [CW-1:0] w, input logic [1:0] ev, input logic [NW-1:0] ec);
        coef_in       = w;
        coef_in_valid = 1'b1;
        #0 check("send.ready", 32'(coef_in_ready), 32'd1);
        tick();
        coef_in_valid = 1'b0;
        check("send.coefo", 32'(coefo), 32'(w));
        check("send.valid", 32'(coefo_valid), 32'(ev));
        check("send.cnt",   32'(load_cnt), 32'(ec));
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        nGrst = 1'b0; clkEn = 1'b1; rstn = 1'b1; load_start = 1'b0;
        coef_in = '0; coef_in_valid = 1'b0; swap_ok = 1'b0;
        #12;
        check("rst.coefo", 32'(coefo), 32'd0);
        check_status("rst", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("rst.ready", 32'(coef_in_ready), 32'd0);
        nGrst = 1'b1;
        tick();

        // First load into bank B, swap_ok held high.
        swap_ok = 1'b1;
        start();
        check_status("t1.start", 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        send(12'h011, 2'b10, 3'd1);
        send(12'h022, 2'b10, 3'd2);
        send(12'h033, 2'b10, 3'd3);
        send(12'h044, 2'b10, 3'd4);
        check("t1.wait_ready", 32'(coef_in_ready), 32'd0);
        check("t1.wait_bank", 32'(bank_sel), 32'd0);
        tick();
        check_status("t1.swap", 2'b00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check_status("t1.idle", 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

        // Second load goes to bank A and swaps back.
        start();
        send(12'h0A1, 2'b01, 3'd1);
        send(12'h0A2, 2'b01, 3'd2);
        send(12'h0A3, 2'b01, 3'd3);
        send(12'h0A4, 2'b01, 3'd4);
        tick();
        check_status("t2.swap", 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Gapped stream, then a long wait for the safe point.
        swap_ok = 1'b0;
        start();
        for (int i = 0; i < TAPS; i++) begin
            send(12'h101 + 12'(i), 2'b10, 3'(i + 1));
            if (i < TAPS - 1) begin
                tick();
                check("t3.gap_valid", 32'(coefo_valid), 32'd0);
                check("t3.gap_cnt",   32'(load_cnt), 32'(i + 1));
            end
        end
        coef_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #0 check("t3.wait_ready", 32'(coef_in_ready), 32'd0);
            tick();
            check_status("t3.wait", 2'b00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        end
        coef_in_valid = 1'b0;
        swap_ok = 1'b1;
        tick();
        swap_ok = 1'b0;
        check_status("t3.swap", 2'b00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);

        // Restart after two words; the coincident word is dropped.
        start();
        send(12'h201, 2'b01, 3'd1);
        send(12'h202, 2'b01, 3'd2);
        load_start = 1'b1; coef_in = 12'h2FF; coef_in_valid = 1'b1;
        tick();
        load_start = 1'b0; coef_in_valid = 1'b0;
        check_status("t4.abort", 2'b00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        check("t4.abort_coefo", 32'(coefo), 32'h202);
        for (int i = 0; i < TAPS; i++) send(12'h211 + 12'(i), 2'b01, 3'(i + 1));
        swap_ok = 1'b1;
        tick();
        swap_ok = 1'b0;
        check_status("t4.swap", 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Clock-enable freeze mid-load.
        start();
        send(12'h301, 2'b10, 3'd1);
        tick();
        coef_in = 12'h302; coef_in_valid = 1'b1; clkEn = 1'b0;
        #0 check("t5.frz_ready", 32'(coef_in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_status("t5.frz", 2'b00, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
            check("t5.frz_coefo", 32'(coefo), 32'h301);
        end
        clkEn = 1'b1;
        send(12'h302, 2'b10, 3'd2);
        send(12'h303, 2'b10, 3'd3);
        send(12'h304, 2'b10, 3'd4);

        // Restart beats swap in WAIT_SWAP.
        load_start = 1'b1; swap_ok = 1'b1;
        tick();
        load_start = 1'b0; swap_ok = 1'b0;
        check_status("t5.restart_wins", 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);

        // Async reset while waiting for the safe point.
        for (int i = 0; i < TAPS; i++) send(12'h401 + 12'(i), 2'b10, 3'(i + 1));
        #3 nGrst = 1'b0;
        #1;
        check("t6.async_coefo", 32'(coefo), 32'd0);
        check_status("t6.async", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nGrst = 1'b1;
        tick();

        // Synchronous clear mid-load.
        start();
        send(12'h501, 2'b10, 3'd1);
        send(12'h502, 2'b10, 3'd2);
        rstn = 1'b0;
        #0 check("t7.pre_cnt", 32'(load_cnt), 32'd2);
        tick();
        rstn = 1'b1;
        check("t7.sync_coefo", 32'(coefo), 32'd0);
        check_status("t7.sync", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Words offered in IDLE are never accepted.
        coef_in = 12'h6AA; coef_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #0 check("t8.idle_ready", 32'(coef_in_ready), 32'd0);
            tick();
            check_status("t8.idle", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        end
        coef_in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
